aes_round_sequencer: RTL

Iterative AES-128 encryption controller that sequences the shared single-round datapath (SubBytes/ShiftRows/MixColumns/AddRoundKey) across all rounds of one block. It accepts a plaintext block over a valid/ready handshake and performs the initial AddRoundKey itself. It issues rounds 1..NR to the datapath one at a time and returns the ciphertext over a valid/ready handshake. It also contains a watchdog that aborts a block if the datapath stalls.

---
 rtl/aes_round_sequencer.sv | 92 +++++++++
 1 files changed

// File: rtl/aes_round_sequencer.sv
// aes_round_sequencer: iterative AES-128 controller that applies the initial AddRoundKey,
// issues rounds 1..NR to a shared round datapath and aborts a block on a datapath stall.
module aes_round_sequencer #(
    parameter int NR      = 10,
    parameter int TIMEOUT = 64,
    parameter int TW      = 7
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_flush,
    input  logic [128*(NR+1)-1:0]   i_key,
    input  logic [127:0]            i_in_data,
    input  logic                    i_in_valid,
    output logic                    o_in_ready,
    output logic [127:0]            o_dp_state,
    output logic [3:0]              o_dp_round,
    output logic                    o_dp_final,
    output logic                    o_dp_start,
    input  logic [127:0]            i_dp_out,
    input  logic                    i_dp_done,
    output logic [127:0]            o_out_data,
    output logic                    o_out_valid,
    input  logic                    i_out_ready,
    output logic                    o_out_err,
    output logic                    o_busy
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    state_t        r_state;
    logic [127:0]  r_st;
    logic [3:0]    r_round;
    logic [TW-1:0] r_wd;
    logic          r_err;
    logic          w_timeout;

    assign w_timeout = r_wd == TW'(TIMEOUT - 1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_st    <= '0;
            r_round <= '0;
            r_wd    <= '0;
            r_err   <= 1'b0;
        end else if (i_flush) begin
            r_state <= IDLE;
            r_round <= '0;
            r_err   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: if (i_in_valid) begin
                    r_st    <= i_in_data ^ i_key[127:0];
                    r_round <= 4'd1;
                    r_err   <= 1'b0;
                    r_state <= ISSUE;
                end
                ISSUE: begin
                    r_wd    <= '0;
                    r_state <= WAIT;
                end
                WAIT: begin
                    r_wd <= r_wd + TW'(1);
                    // a completion arriving on the last watchdog cycle still counts
                    if (i_dp_done) begin
                        r_st <= i_dp_out;
                        if (r_round == 4'(NR)) begin
                            r_state <= DONE;
                        end else begin
                            r_round <= r_round + 4'd1;
                            r_state <= ISSUE;
                        end
                    end else if (w_timeout) begin
                        r_err   <= 1'b1;
                        r_state <= DONE;
                    end
                end
                DONE: if (i_out_ready) r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    assign o_in_ready  = r_state == IDLE;
    assign o_busy      = r_state != IDLE;
    assign o_dp_start  = r_state == ISSUE;
    assign o_dp_state  = r_st;
    assign o_dp_round  = r_round;
    assign o_dp_final  = r_round == 4'(NR);
    assign o_out_valid = r_state == DONE;
    assign o_out_data  = (r_state == DONE) ? r_st : '0;
    assign o_out_err   = (r_state == DONE) & r_err;
endmodule
